ie_stage: RTL and testbench

IE_STAGE -- requirements
Module: ie_stage

---
 rtl/ie_stage.sv | 191 +++++++++++++++++++
 tb/tb_ie_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ie_stage.sv
// ie_stage: integer execute stage. Single-cycle ALU ops plus a 16-step
// iterative shift-add multiplier that stalls upstream while it runs.
module ie_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  opcode_in,
   input  logic [1:0]  mode_in,
   input  logic [15:0] op1_in,
   input  logic [15:0] op2_in,
   input  logic [3:0]  wb_reg_in,
   output logic        stall_out,
   output logic [15:0] result_out,
   output logic [3:0]  wb_reg_out,
   output logic        wb_en_out,
   output logic [3:0]  flags_out,
   output logic        out_valid,
   output logic        illegal_op
);

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_SUB = 8'h02;
   localparam logic [7:0] OP_AND = 8'h03;
   localparam logic [7:0] OP_OR  = 8'h04;
   localparam logic [7:0] OP_XOR = 8'h05;
   localparam logic [7:0] OP_SHL = 8'h06;
   localparam logic [7:0] OP_SHR = 8'h07;
   localparam logic [7:0] OP_MUL = 8'h08;
   localparam logic [7:0] OP_CMP = 8'h09;

   typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

   // Everything needed to retire one instruction into the output registers.
   typedef struct packed {
      logic [7:0]  op;
      logic [1:0]  mode;
      logic [3:0]  wb;
      logic [15:0] res;
      logic        c;
      logic        v;
      logic        legal;
   } cpl_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [15:0] mcand, mplier, acc;
   logic [1:0]  mul_mode;
   logic [3:0]  mul_wb;

   logic        accept, alu_fire, mul_fire, mul_last, done;
   logic [4:0]  cnt_inc;
   logic [15:0] mul_sum;
   logic [16:0] sum, diff, shl_w, shr_w;
   logic        flag_upd, wb_req;
   cpl_t        alu, cpl;

   // stall_out is high exactly while the multiplier owns the stage
   assign accept   = in_valid && !stall_out;
   assign alu_fire = accept && (opcode_in != OP_MUL);
   assign mul_fire = accept && (opcode_in == OP_MUL);
   assign cnt_inc  = cnt + 5'd1;
   // cnt counts finished shift-add steps; the step that brings it to 16 retires
   assign mul_last = (state == MUL_RUN) && (cnt_inc == 5'd16);
   assign mul_sum  = acc + (mplier[0] ? mcand : 16'h0000);
   assign done     = alu_fire || mul_last;

   // Single-cycle datapath: result plus carry/overflow for the incoming op
   always_comb begin
      sum   = {1'b0, op1_in} + {1'b0, op2_in};
      diff  = {1'b0, op1_in} - {1'b0, op2_in};
      // bit 16 of the left shift / bit 0 of the right shift is the last bit out
      shl_w = {1'b0, op1_in} << op2_in[3:0];
      shr_w = {op1_in, 1'b0} >> op2_in[3:0];
      alu       = '0;
      alu.op    = opcode_in;
      alu.mode  = mode_in;
      alu.wb    = wb_reg_in;
      alu.legal = 1'b1;
      case (opcode_in)
         OP_NOP: alu.res = 16'h0000;
         OP_ADD: begin
            alu.res = sum[15:0];
            alu.c   = sum[16];
            alu.v   = (op1_in[15] == op2_in[15]) && (sum[15] != op1_in[15]);
         end
         OP_SUB, OP_CMP: begin
            alu.res = diff[15:0];
            alu.c   = diff[16];
            alu.v   = (op1_in[15] != op2_in[15]) && (diff[15] != op1_in[15]);
         end
         OP_AND: alu.res = op1_in & op2_in;
         OP_OR:  alu.res = op1_in | op2_in;
         OP_XOR: alu.res = op1_in ^ op2_in;
         OP_SHL: begin
            alu.res = shl_w[15:0];
            alu.c   = shl_w[16];
         end
         OP_SHR: begin
            alu.res = shr_w[16:1];
            alu.c   = shr_w[0];
         end
         OP_MUL: alu.res = 16'h0000;
         default: alu.legal = 1'b0;
      endcase
   end

   // Pick the retiring instruction: the multiplier's final step or the ALU op
   always_comb begin
      cpl = alu;
      if (mul_last) begin
         cpl       = '0;
         cpl.op    = OP_MUL;
         cpl.mode  = mul_mode;
         cpl.wb    = mul_wb;
         cpl.res   = mul_sum;
         cpl.legal = 1'b1;
      end
   end

   assign flag_upd = cpl.legal && ((cpl.mode == 2'b01) || (cpl.mode == 2'b10) || (cpl.op == OP_CMP));
   assign wb_req   = cpl.legal && !cpl.mode[1] && (cpl.op != OP_NOP) && (cpl.op != OP_CMP);

   // Multiplier FSM: IDLE accepts, MUL_RUN runs 16 shift-add steps
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         stall_out <= 1'b0;
         cnt       <= 5'd0;
         mcand     <= 16'h0000;
         mplier    <= 16'h0000;
         acc       <= 16'h0000;
         mul_mode  <= 2'b00;
         mul_wb    <= 4'h0;
      end else begin
         case (state)
            IDLE: begin
               if (mul_fire) begin
                  state     <= MUL_RUN;
                  stall_out <= 1'b1;
                  cnt       <= 5'd0;
                  mcand     <= op1_in;
                  mplier    <= op2_in;
                  acc       <= 16'h0000;
                  mul_mode  <= mode_in;
                  mul_wb    <= wb_reg_in;
               end
            end
            MUL_RUN: begin
               acc    <= mul_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (mul_last) begin
                  state     <= IDLE;
                  stall_out <= 1'b0;
                  cnt       <= 5'd0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state     <= IDLE;
               stall_out <= 1'b0;
            end
         endcase
      end
   end

   // Output registers: pulses on retire, result/index/flags hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         result_out <= 16'h0000;
         wb_reg_out <= 4'h0;
         flags_out  <= 4'h0;
         wb_en_out  <= 1'b0;
         out_valid  <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         out_valid  <= done;
         illegal_op <= done && !cpl.legal;
         wb_en_out  <= done && wb_req;
         if (done) begin
            result_out <= cpl.res;
            wb_reg_out <= cpl.wb;
         end
         if (done && flag_upd)
            flags_out <= {(cpl.res == 16'h0000), cpl.res[15], cpl.c, cpl.v};
      end
   end

endmodule

// File: tb/tb_ie_stage.sv
// tb_ie_stage: directed and randomized checks of ie_stage against an
// arithmetic reference model of the execute stage.
module tb_ie_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  opcode_in = 8'h00;
   logic [1:0]  mode_in = 2'b00;
   logic [15:0] op1_in = 16'h0000;
   logic [15:0] op2_in = 16'h0000;
   logic [3:0]  wb_reg_in = 4'h0;
   logic        stall_out;
   logic [15:0] result_out;
   logic [3:0]  wb_reg_out;
   logic        wb_en_out;
   logic [3:0]  flags_out;
   logic        out_valid;
   logic        illegal_op;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [15:0] m_res = 16'h0000;
   logic [3:0]  m_wb = 4'h0;
   logic [3:0]  m_flags = 4'h0;
   logic        m_wben = 1'b0;
   logic        m_ill = 1'b0;

   ie_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .opcode_in(opcode_in),
      .mode_in(mode_in), .op1_in(op1_in), .op2_in(op2_in), .wb_reg_in(wb_reg_in),
      .stall_out(stall_out), .result_out(result_out), .wb_reg_out(wb_reg_out),
      .wb_en_out(wb_en_out), .flags_out(flags_out), .out_valid(out_valid),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic [1:0] md,
                        input logic [15:0] a, input logic [15:0] b, input logic [3:0] wb);
      in_valid  = 1'b1;
      opcode_in = op;
      mode_in   = md;
      op1_in    = a;
      op2_in    = b;
      wb_reg_in = wb;
   endtask

   task automatic model_reset;
      m_res = 16'h0000; m_wb = 4'h0; m_flags = 4'h0; m_wben = 1'b0; m_ill = 1'b0;
   endtask

   // Reference semantics in plain integer arithmetic
   task automatic model_apply(input logic [7:0] op, input logic [1:0] md,
                              input logic [15:0] a, input logic [15:0] b, input logic [3:0] wb);
      int ia, ib, sa, sb, r, sr, s;
      logic c, v, legal;
      logic [15:0] res;
      ia = a; ib = b; sa = $signed(a); sb = $signed(b); s = ib % 16;
      r = 0; sr = 0; c = 1'b0; v = 1'b0;
      legal = (op <= 8'd9);
      case (op)
         8'd1: begin r = ia + ib; c = (r > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
         8'd2, 8'd9: begin r = ia - ib; c = (ia < ib); sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
         8'd3: r = ia & ib;
         8'd4: r = ia | ib;
         8'd5: r = ia ^ ib;
         8'd6: begin r = ia << s; c = (s != 0) && (((ia >> (16 - s)) & 1) == 1); end
         8'd7: begin r = ia >> s; c = (s != 0) && (((ia >> (s - 1)) & 1) == 1); end
         8'd8: r = ia * ib;
         default: r = 0;
      endcase
      res    = r[15:0];
      m_res  = res;
      m_wb   = wb;
      m_ill  = !legal;
      m_wben = legal && !md[1] && (op != 8'd0) && (op != 8'd9);
      if (legal && (md == 2'b01 || md == 2'b10 || op == 8'd9))
         m_flags = {(res == 16'h0000), res[15], c, v};
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 6))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h7FFF;
         3: return 16'h8000;
         4: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      drive(8'h01, 2'b01, 16'h1234, 16'h0001, 4'h5);
      tick; tick;
      tests++;
      if ({stall_out, out_valid, illegal_op, wb_en_out, result_out, wb_reg_out, flags_out} !== 29'h0) begin
         fails++;
         $display("FAIL reset: got stall=%b ov=%b ill=%b wen=%b res=%04h wb=%0d fl=%04b, want all zero",
                  stall_out, out_valid, illegal_op, wb_en_out, result_out, wb_reg_out, flags_out);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      model_reset();
      tick;
   endtask

   task automatic test_arith_directed;
      drive(8'h01, 2'b01, 16'h7FFF, 16'h0001, 4'h3);
      tick; model_apply(8'h01, 2'b01, 16'h7FFF, 16'h0001, 4'h3);
      tests++;
      if (out_valid !== 1'b1 || result_out !== 16'h8000 || wb_en_out !== 1'b1 || wb_reg_out !== 4'h3 || flags_out !== 4'b0101) begin
         fails++;
         $display("FAIL add_ovf: got ov=%b res=%04h wen=%b wb=%0d fl=%04b, want 1 8000 1 3 0101",
                  out_valid, result_out, wb_en_out, wb_reg_out, flags_out);
      end
      drive(8'h02, 2'b10, 16'h0001, 16'h0002, 4'h5);
      tick; model_apply(8'h02, 2'b10, 16'h0001, 16'h0002, 4'h5);
      tests++;
      if (out_valid !== 1'b1 || result_out !== 16'hFFFF || wb_en_out !== 1'b0 || flags_out !== 4'b0110) begin
         fails++;
         $display("FAIL sub_borrow: got ov=%b res=%04h wen=%b fl=%04b, want 1 ffff 0 0110",
                  out_valid, result_out, wb_en_out, flags_out);
      end
      drive(8'h06, 2'b01, 16'hA5A5, 16'h0010, 4'h1);
      tick; model_apply(8'h06, 2'b01, 16'hA5A5, 16'h0010, 4'h1);
      tests++;
      if (result_out !== 16'hA5A5 || flags_out !== 4'b0100) begin
         fails++;
         $display("FAIL shl_zero: got res=%04h fl=%04b, want a5a5 0100", result_out, flags_out);
      end
      drive(8'h06, 2'b01, 16'hC000, 16'h0001, 4'h2);
      tick; model_apply(8'h06, 2'b01, 16'hC000, 16'h0001, 4'h2);
      tests++;
      if (result_out !== 16'h8000 || flags_out !== 4'b0110) begin
         fails++;
         $display("FAIL shl_carry: got res=%04h fl=%04b, want 8000 0110", result_out, flags_out);
      end
      drive(8'h07, 2'b10, 16'h0003, 16'h0001, 4'h2);
      tick; model_apply(8'h07, 2'b10, 16'h0003, 16'h0001, 4'h2);
      tests++;
      if (result_out !== 16'h0001 || flags_out !== 4'b0010 || wb_en_out !== 1'b0) begin
         fails++;
         $display("FAIL shr_carry: got res=%04h fl=%04b wen=%b, want 0001 0010 0", result_out, flags_out, wb_en_out);
      end
      drive(8'h09, 2'b00, 16'h0005, 16'h0005, 4'h4);
      tick; model_apply(8'h09, 2'b00, 16'h0005, 16'h0005, 4'h4);
      tests++;
      if (out_valid !== 1'b1 || wb_en_out !== 1'b0 || flags_out !== 4'b1000) begin
         fails++;
         $display("FAIL cmp_mode00: got ov=%b wen=%b fl=%04b, want 1 0 1000", out_valid, wb_en_out, flags_out);
      end
      in_valid = 1'b0;
      tick;
   endtask

   task automatic test_mul;
      logic [3:0] fl_before;
      fl_before = m_flags;
      drive(8'h08, 2'b00, 16'h0123, 16'h0010, 4'h6);
      tick; model_apply(8'h08, 2'b00, 16'h0123, 16'h0010, 4'h6);
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (stall_out !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mul_stall cyc%0d: got stall=%b ov=%b, want 1 0", i + 1, stall_out, out_valid);
         end
         tick;
      end
      tests++;
      if (stall_out !== 1'b0 || out_valid !== 1'b1 || result_out !== 16'h1230 || wb_en_out !== 1'b1 ||
          wb_reg_out !== 4'h6 || flags_out !== fl_before) begin
         fails++;
         $display("FAIL mul_done: got stall=%b ov=%b res=%04h wen=%b wb=%0d fl=%04b, want 0 1 1230 1 6 %04b",
                  stall_out, out_valid, result_out, wb_en_out, wb_reg_out, flags_out, fl_before);
      end
      tick;
      tests++;
      if (out_valid !== 1'b0 || wb_en_out !== 1'b0 || result_out !== 16'h1230) begin
         fails++;
         $display("FAIL mul_after: got ov=%b wen=%b res=%04h, want 0 0 1230", out_valid, wb_en_out, result_out);
      end
   endtask

   task automatic test_mul_hold;
      logic [15:0] ma, mb, aa, ab;
      int pulses;
      ma = pick(); mb = pick(); aa = pick(); ab = pick();
      pulses = 0;
      drive(8'h08, 2'b01, ma, mb, 4'h7);
      tick; model_apply(8'h08, 2'b01, ma, mb, 4'h7);
      drive(8'h01, 2'b00, aa, ab, 4'h9);
      for (int t = 1; t <= 24; t++) begin
         tick;
         if (t == 17) in_valid = 1'b0;
         if (out_valid === 1'b1) begin
            pulses++;
            if (t == 17) model_apply(8'h01, 2'b00, aa, ab, 4'h9);
            tests++;
            if ((t != 16 && t != 17) || result_out !== m_res || wb_reg_out !== m_wb ||
                wb_en_out !== m_wben || flags_out !== m_flags) begin
               fails++;
               $display("FAIL mul_hold t=%0d: got res=%04h wb=%0d wen=%b fl=%04b, want res=%04h wb=%0d wen=%b fl=%04b at t=16/17",
                        t, result_out, wb_reg_out, wb_en_out, flags_out, m_res, m_wb, m_wben, m_flags);
            end
         end
      end
      tests++;
      if (pulses != 2) begin
         fails++;
         $display("FAIL mul_hold_pulses: got %0d out_valid pulses, want 2", pulses);
      end
   endtask

   task automatic test_illegal;
      logic [7:0] op;
      for (int i = 0; i < 8; i++) begin
         op = (i == 0) ? 8'hFF : 8'($urandom_range(10, 255));
         drive(op, 2'b01, pick(), pick(), 4'($urandom));
         tick; model_apply(op, 2'b01, op1_in, op2_in, wb_reg_in);
         tests++;
         if (out_valid !== 1'b1 || illegal_op !== 1'b1 || wb_en_out !== 1'b0 || flags_out !== m_flags || wb_reg_out !== m_wb) begin
            fails++;
            $display("FAIL illegal op=%02h: got ov=%b ill=%b wen=%b fl=%04b wb=%0d, want 1 1 0 %04b %0d",
                     op, out_valid, illegal_op, wb_en_out, flags_out, wb_reg_out, m_flags, m_wb);
         end
      end
      in_valid = 1'b0;
      tick;
      tests++;
      if (out_valid !== 1'b0 || illegal_op !== 1'b0) begin
         fails++;
         $display("FAIL illegal_pulse: got ov=%b ill=%b after idle, want 0 0", out_valid, illegal_op);
      end
   endtask

   task automatic test_reset_mid_mul;
      int pulses;
      pulses = 0;
      drive(8'h08, 2'b01, 16'h1111, 16'h2222, 4'hA);
      tick;
      in_valid = 1'b0;
      repeat (7) tick;
      rst = 1'b1;
      drive(8'h08, 2'b01, 16'h3333, 16'h0002, 4'hB);
      tick;
      rst = 1'b0;
      in_valid = 1'b0;
      model_reset();
      tests++;
      if (stall_out !== 1'b0 || out_valid !== 1'b0 || result_out !== 16'h0 || flags_out !== 4'h0 || wb_reg_out !== 4'h0) begin
         fails++;
         $display("FAIL rst_mid_mul: got stall=%b ov=%b res=%04h fl=%04b wb=%0d, want all zero",
                  stall_out, out_valid, result_out, flags_out, wb_reg_out);
      end
      for (int t = 0; t < 20; t++) begin
         tick;
         if (out_valid === 1'b1 || stall_out === 1'b1) pulses++;
      end
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL rst_abort: got %0d busy/valid cycles after reset, want 0", pulses);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] op;
      for (int i = 0; i < 12; i++) begin
         op = (i % 2 == 0) ? 8'($urandom_range(1, 7)) : 8'h09;
         drive(op, 2'($urandom), pick(), pick(), 4'($urandom));
         tick; model_apply(op, mode_in, op1_in, op2_in, wb_reg_in);
         tests++;
         if (out_valid !== 1'b1 || result_out !== m_res || wb_en_out !== m_wben || flags_out !== m_flags || wb_reg_out !== m_wb) begin
            fails++;
            $display("FAIL b2b #%0d op=%02h: got ov=%b res=%04h wen=%b fl=%04b wb=%0d, want 1 %04h %b %04b %0d",
                     i, op, out_valid, result_out, wb_en_out, flags_out, wb_reg_out, m_res, m_wben, m_flags, m_wb);
         end
      end
      in_valid = 1'b0;
      tick;
   endtask

   task automatic test_random;
      logic [7:0] op;
      int r;
      bit chk_res;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            drive(8'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
            in_valid = 1'b0;
            tick;
            tests++;
            if (out_valid !== 1'b0 || wb_en_out !== 1'b0 || illegal_op !== 1'b0 || result_out !== m_res ||
                wb_reg_out !== m_wb || flags_out !== m_flags) begin
               fails++;
               $display("FAIL rand_idle #%0d: got ov=%b wen=%b ill=%b res=%04h wb=%0d fl=%04b, want 0 0 0 %04h %0d %04b",
                        n, out_valid, wb_en_out, illegal_op, result_out, wb_reg_out, flags_out, m_res, m_wb, m_flags);
            end
            continue;
         end
         r = $urandom_range(0, 21);
         op = (r < 20) ? 8'(r % 10) : 8'($urandom_range(10, 255));
         drive(op, 2'($urandom), pick(), pick(), 4'($urandom));
         model_apply(op, mode_in, op1_in, op2_in, wb_reg_in);
         chk_res = (op >= 8'd1) && (op <= 8'd9);
         tick;
         if (op == 8'h08) begin
            for (int k = 1; k <= 16; k++) begin
               tests++;
               if (stall_out !== 1'b1 || out_valid !== 1'b0) begin
                  fails++;
                  $display("FAIL rand_mul_busy #%0d k=%0d: got stall=%b ov=%b, want 1 0", n, k, stall_out, out_valid);
               end
               drive(8'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
               in_valid = stall_out ? 1'($urandom) : 1'b0;
               tick;
            end
            in_valid = 1'b0;
         end
         tests++;
         if (out_valid !== 1'b1 || stall_out !== 1'b0 || illegal_op !== m_ill || wb_en_out !== m_wben ||
             wb_reg_out !== m_wb || flags_out !== m_flags || (chk_res && result_out !== m_res)) begin
            fails++;
            $display("FAIL rand #%0d op=%02h: got ov=%b ill=%b wen=%b res=%04h wb=%0d fl=%04b, want 1 %b %b %04h %0d %04b",
                     n, op, out_valid, illegal_op, wb_en_out, result_out, wb_reg_out, flags_out,
                     m_ill, m_wben, m_res, m_wb, m_flags);
         end
      end
      in_valid = 1'b0;
      tick;
   endtask

   initial begin
      test_reset();
      test_arith_directed();
      test_mul();
      test_mul_hold();
      test_illegal();
      test_reset_mid_mul();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
